// File: rtl/bka_multiword_add_seq.sv
// bka_multiword_add_seq
// Word-serial sequencer wrapped around an external combinational W-bit adder
// slice. Operands arrive LS word first. Carry is chained from word to word,
// and each result word is registered into a single-entry output stage, so one
// narrow slice can perform N*W-bit add and subtract.
module bka_multiword_add_seq #(
    parameter  int W         = 16,
    parameter  int MAX_WORDS = 8,
    localparam int CW        = $clog2(MAX_WORDS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_x,
    input  logic [W-1:0]  in_y,
    input  logic          in_last,
    input  logic          in_sub,
    output logic [W-1:0]  add_x,
    output logic [W-1:0]  add_y,
    output logic          add_cin,
    input  logic [W:0]    add_s,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_sum,
    output logic [CW-1:0] out_idx,
    output logic          out_last,
    output logic          out_cout,
    output logic          out_ovf,
    output logic          out_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic          carry_q;
    logic          op_q;
    logic [CW-1:0] cnt;

    logic accept;
    logic is_idle;
    logic sub_e;
    logic forced;
    logic ends;
    logic ovf_w;

    // Signed overflow of a two's-complement add: both operands share a sign
    // that the result does not.
    function automatic logic signed_ovf(input logic xs, input logic ys, input logic ss);
        return (xs == ys) && (ss != xs);
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign is_idle  = (state == IDLE);

    // The operation is latched from the first word; later words ignore in_sub.
    assign sub_e    = is_idle ? in_sub : op_q;

    // Subtraction is X + ~Y + 1: the +1 enters as Cin on the LS word only.
    assign add_x    = in_x;
    assign add_y    = sub_e ? ~in_y : in_y;
    assign add_cin  = is_idle ? sub_e : carry_q;

    // A transaction that reaches MAX_WORDS without a last flag is cut off here.
    assign forced   = (cnt == CW'(MAX_WORDS - 1)) && !in_last;
    assign ends     = in_last || forced;
    assign ovf_w    = signed_ovf(in_x[W-1], add_y[W-1], add_s[W-1]);

    // Transaction FSM, carry chain and registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            carry_q   <= 1'b0;
            op_q      <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_sum   <= add_s[W-1:0];
            out_idx   <= cnt;
            out_last  <= ends;
            out_err   <= forced;
            out_cout  <= ends ? add_s[W] : 1'b0;
            out_ovf   <= ends ? ovf_w : 1'b0;
            if (is_idle) begin
                op_q <= in_sub;
            end
            if (ends) begin
                // Closing word: the chain ends, so its carry is dropped.
                state   <= IDLE;
                cnt     <= '0;
                carry_q <= 1'b0;
            end else begin
                state   <= BUSY;
                cnt     <= cnt + 1'b1;
                carry_q <= add_s[W];
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
